butterfly: RTL and testbench

BUTTERFLY -- requirements
Module: butterfly

---
 rtl/butterfly_if.sv | 29 ++
 rtl/butterfly.sv | 125 ++++++++++++
 tb/tb_butterfly.sv | 226 ++++++++++++++++++++++
 3 files changed

// File: rtl/butterfly_if.sv
// ---------------------------------------------------------------------------
// butterfly_if -- data bundle for the radix-4 butterfly.
//
// Signals:
//   in_valid          high when Ar..Di carry a valid input set this cycle
//   Ar..Di            real/imag of complex inputs A, B, C, D (16-bit signed)
//   out_valid         high when out0r..out3i carry a valid result set
//   out0r..out3i      real/imag of complex results X0..X3 (16-bit signed)
//
// Modports:
//   master  drives the inputs and observes the results (stimulus side)
//   slave   the butterfly itself
// ---------------------------------------------------------------------------
interface butterfly_if;
  logic               in_valid;
  logic signed [15:0] Ar, Ai, Br, Bi, Cr, Ci, Dr, Di;
  logic               out_valid;
  logic signed [15:0] out0r, out0i, out1r, out1i, out2r, out2i, out3r, out3i;

  modport master (
    output in_valid, Ar, Ai, Br, Bi, Cr, Ci, Dr, Di,
    input  out_valid, out0r, out0i, out1r, out1i, out2r, out2i, out3r, out3i
  );

  modport slave (
    input  in_valid, Ar, Ai, Br, Bi, Cr, Ci, Dr, Di,
    output out_valid, out0r, out0i, out1r, out1i, out2r, out2i, out3r, out3i
  );
endinterface

// File: rtl/butterfly.sv
// ---------------------------------------------------------------------------
// butterfly -- two-stage pipelined radix-4 DIT butterfly (4-point DFT).
//
//   X0 = A + B + C + D       X1 = A - jB - C + jD
//   X2 = A - B + C - D       X3 = A + jB - C - jD
//
// Ports:
//   clk    single clock, rising edge
//   rst_n  asynchronous active-low reset; clears every register and output
//   bus    butterfly_if.slave (in_valid, Ar..Di in; out_valid, out0r..out3i out)
//
// Latency is 2 cycles; a new input set is accepted every cycle.
//
// Build option:
//   BUTTERFLY_SCALE_EN  defined   -> each 18-bit sum is scaled by 1/4 with
//                                    round half up: (sum + 2) >>> 2
//                       undefined -> each 18-bit sum is saturated to 16 bits
// ---------------------------------------------------------------------------
module butterfly (
  input  logic  clk,
  input  logic  rst_n,
  butterfly_if.slave bus
);

  // Stage 1: pairwise sums/differences, A with C and B with D.
  logic signed [16:0] s1_apc_r, s1_apc_i, s1_amc_r, s1_amc_i;
  logic signed [16:0] s1_bpd_r, s1_bpd_i, s1_bmd_r, s1_bmd_i;
  logic               s1_valid;

  // Stage 2: post-processed results.
  logic signed [15:0] s2_x0r, s2_x0i, s2_x1r, s2_x1i;
  logic signed [15:0] s2_x2r, s2_x2i, s2_x3r, s2_x3i;
  logic               s2_valid;

  // Full-width 18-bit sums feeding stage 2.
  logic signed [17:0] x0r_sum, x0i_sum, x1r_sum, x1i_sum;
  logic signed [17:0] x2r_sum, x2i_sum, x3r_sum, x3i_sum;

  // Reduce an 18-bit sum to the 16-bit output format.
  function automatic logic signed [15:0] post(input logic signed [17:0] s);
`ifdef BUTTERFLY_SCALE_EN
    // |sum| <= 4*32768, so sum+2 never overflows 18 bits and the shifted
    // value always fits in 16 bits.
    return 16'((s + 18'sd2) >>> 2);
`else
    if (s > 18'sd32767)
      return 16'sh7fff;
    else if (s < -18'sd32768)
      return 16'sh8000;
    else
      return s[15:0];
`endif
  endfunction

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge value of its sources regardless of block order.
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: the data registers are reset along with the valid bits because
    // the outputs must read 0 during reset, not stale data.
    if (!rst_n) begin
      s1_apc_r <= '0;  s1_apc_i <= '0;
      s1_amc_r <= '0;  s1_amc_i <= '0;
      s1_bpd_r <= '0;  s1_bpd_i <= '0;
      s1_bmd_r <= '0;  s1_bmd_i <= '0;
      s1_valid <= 1'b0;
    end else begin
      s1_valid <= bus.in_valid;
      if (bus.in_valid) begin
        s1_apc_r <= 17'(bus.Ar) + 17'(bus.Cr);
        s1_apc_i <= 17'(bus.Ai) + 17'(bus.Ci);
        s1_amc_r <= 17'(bus.Ar) - 17'(bus.Cr);
        s1_amc_i <= 17'(bus.Ai) - 17'(bus.Ci);
        s1_bpd_r <= 17'(bus.Br) + 17'(bus.Dr);
        s1_bpd_i <= 17'(bus.Bi) + 17'(bus.Di);
        s1_bmd_r <= 17'(bus.Br) - 17'(bus.Dr);
        s1_bmd_i <= 17'(bus.Bi) - 17'(bus.Di);
      end
    end
  end

  // -jB + jD = ((Bi-Di), -(Br-Dr)); +jB - jD is its negation.
  always_comb begin
    x0r_sum = 18'(s1_apc_r) + 18'(s1_bpd_r);
    x0i_sum = 18'(s1_apc_i) + 18'(s1_bpd_i);
    x2r_sum = 18'(s1_apc_r) - 18'(s1_bpd_r);
    x2i_sum = 18'(s1_apc_i) - 18'(s1_bpd_i);
    x1r_sum = 18'(s1_amc_r) + 18'(s1_bmd_i);
    x1i_sum = 18'(s1_amc_i) - 18'(s1_bmd_r);
    x3r_sum = 18'(s1_amc_r) - 18'(s1_bmd_i);
    x3i_sum = 18'(s1_amc_i) + 18'(s1_bmd_r);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s2_x0r <= '0;  s2_x0i <= '0;
      s2_x1r <= '0;  s2_x1i <= '0;
      s2_x2r <= '0;  s2_x2i <= '0;
      s2_x3r <= '0;  s2_x3i <= '0;
      s2_valid <= 1'b0;
    end else begin
      s2_valid <= s1_valid;
      if (s1_valid) begin
        s2_x0r <= post(x0r_sum);
        s2_x0i <= post(x0i_sum);
        s2_x1r <= post(x1r_sum);
        s2_x1i <= post(x1i_sum);
        s2_x2r <= post(x2r_sum);
        s2_x2i <= post(x2i_sum);
        s2_x3r <= post(x3r_sum);
        s2_x3i <= post(x3i_sum);
      end
    end
  end

  assign bus.out_valid = s2_valid;
  assign bus.out0r     = s2_x0r;
  assign bus.out0i     = s2_x0i;
  assign bus.out1r     = s2_x1r;
  assign bus.out1i     = s2_x1i;
  assign bus.out2r     = s2_x2r;
  assign bus.out2i     = s2_x2i;
  assign bus.out3r     = s2_x3r;
  assign bus.out3i     = s2_x3i;

endmodule

// File: tb/tb_butterfly.sv
// ---------------------------------------------------------------------------
// tb_butterfly -- self-checking bench for butterfly.
//
// A reference model computes the 4-point DFT of each accepted input set with
// integer arithmetic, applies the build's post-processing, and tracks what the
// outputs should show two cycles later (results hold across gaps, reset
// clears everything). Directed cases cover impulse, DC, rotation, extremes,
// streaming and asynchronous reset; random traffic with gaps follows.
// Build option BUTTERFLY_SCALE_EN must match the RTL build.
// ---------------------------------------------------------------------------
module tb_butterfly;

  typedef struct packed {
    logic signed [15:0] ar, ai, br, bi, cr, ci, dr, di;
  } in_t;

  typedef struct packed {
    logic signed [15:0] x0r, x0i, x1r, x1i, x2r, x2i, x3r, x3i;
  } res_t;

`ifdef BUTTERFLY_SCALE_EN
  localparam int IMP_OUT = 25;
  localparam int DC_X0R  = 4000;
`else
  localparam int IMP_OUT = 100;
  localparam int DC_X0R  = 16000;
`endif

  logic clk = 1'b0;
  logic rst_n;

  butterfly_if bus ();

  butterfly dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Model state: input currently presented, stage-1 content, visible result.
  bit   cur_v;
  in_t  cur;
  bit   p1_v;
  res_t p1_x;
  bit   exp_v;
  res_t exp_x;

  task automatic check(input string tag, input int got, input int exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic logic signed [15:0] post(input int s);
`ifdef BUTTERFLY_SCALE_EN
    int q;
    q = (s + 2) >>> 2;   // int is signed: arithmetic shift = floor divide
    return 16'(q);
`else
    if (s > 32767)  return 16'sh7fff;
    if (s < -32768) return 16'sh8000;
    return 16'(s);
`endif
  endfunction

  function automatic res_t dft4(input in_t s);
    int ar, ai, br, bi, cr, ci, dr, di;
    res_t r;
    ar = s.ar; ai = s.ai; br = s.br; bi = s.bi;
    cr = s.cr; ci = s.ci; dr = s.dr; di = s.di;
    r.x0r = post(ar + br + cr + dr);
    r.x0i = post(ai + bi + ci + di);
    r.x1r = post(ar + bi - cr - di);
    r.x1i = post(ai - br - ci + dr);
    r.x2r = post(ar - br + cr - dr);
    r.x2i = post(ai - bi + ci - di);
    r.x3r = post(ar - bi - cr + di);
    r.x3i = post(ai + br - ci - dr);
    return r;
  endfunction

  task automatic drive(input bit v, input in_t s);
    bus.in_valid = v;
    bus.Ar = s.ar; bus.Ai = s.ai; bus.Br = s.br; bus.Bi = s.bi;
    bus.Cr = s.cr; bus.Ci = s.ci; bus.Dr = s.dr; bus.Di = s.di;
    cur_v = v;
    cur   = s;
  endtask

  task automatic check_outputs(input string ph);
    check({ph, ".out_valid"}, int'(bus.out_valid), int'(exp_v));
    check({ph, ".out0r"}, int'(bus.out0r), int'(exp_x.x0r));
    check({ph, ".out0i"}, int'(bus.out0i), int'(exp_x.x0i));
    check({ph, ".out1r"}, int'(bus.out1r), int'(exp_x.x1r));
    check({ph, ".out1i"}, int'(bus.out1i), int'(exp_x.x1i));
    check({ph, ".out2r"}, int'(bus.out2r), int'(exp_x.x2r));
    check({ph, ".out2i"}, int'(bus.out2i), int'(exp_x.x2i));
    check({ph, ".out3r"}, int'(bus.out3r), int'(exp_x.x3r));
    check({ph, ".out3i"}, int'(bus.out3i), int'(exp_x.x3i));
  endtask

  // One clock: advance the model across the edge, compare, then present the
  // next input set.
  task automatic cycle(input string ph, input bit v, input in_t s);
    @(posedge clk);
    #1;
    exp_v = p1_v;
    if (p1_v) exp_x = p1_x;
    p1_v = cur_v;
    if (cur_v) p1_x = dft4(cur);
    check_outputs(ph);
    drive(v, s);
  endtask

  function automatic in_t mk(input int ar, ai, br, bi, cr, ci, dr, di);
    in_t s;
    s.ar = 16'(ar); s.ai = 16'(ai); s.br = 16'(br); s.bi = 16'(bi);
    s.cr = 16'(cr); s.ci = 16'(ci); s.dr = 16'(dr); s.di = 16'(di);
    return s;
  endfunction

  function automatic logic signed [15:0] rnd16();
    case ($urandom_range(0, 5))
      0:       return 16'sh7fff;
      1:       return 16'sh8000;
      default: return 16'($urandom);
    endcase
  endfunction

  function automatic in_t rnd_in();
    in_t s;
    s.ar = rnd16(); s.ai = rnd16(); s.br = rnd16(); s.bi = rnd16();
    s.cr = rnd16(); s.ci = rnd16(); s.dr = rnd16(); s.di = rnd16();
    return s;
  endfunction

  task automatic model_reset();
    p1_v  = 1'b0;
    p1_x  = '0;
    exp_v = 1'b0;
    exp_x = '0;
  endtask

  in_t zero;

  initial begin
    zero = '0;
    model_reset();
    drive(1'b0, zero);
    rst_n = 1'b0;
    #3;
    check_outputs("reset");
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    // Impulse: all four outputs equal A (scaled or not).
    cycle("idle", 1'b0, zero);
    cycle("imp", 1'b1, mk(100, 0, 0, 0, 0, 0, 0, 0));
    cycle("imp", 1'b0, zero);
    cycle("imp", 1'b0, zero);
    check("imp.valid", int'(bus.out_valid), 1);
    check("imp.x0r", int'(bus.out0r), IMP_OUT);
    check("imp.x3r", int'(bus.out3r), IMP_OUT);
    check("imp.x2i", int'(bus.out2i), 0);
    cycle("imp.hold", 1'b0, zero);
    check("imp.hold.x1r", int'(bus.out1r), IMP_OUT);

    // DC.
    cycle("dc", 1'b1, mk(4000, 0, 4000, 0, 4000, 0, 4000, 0));
    cycle("dc", 1'b0, zero);
    cycle("dc", 1'b0, zero);
    check("dc.x0r", int'(bus.out0r), DC_X0R);
    check("dc.x1r", int'(bus.out1r), 0);

    // Rotation: B = j400.
    cycle("rot", 1'b1, mk(0, 0, 0, 400, 0, 0, 0, 0));
    cycle("rot", 1'b0, zero);
    cycle("rot", 1'b0, zero);

    // Extremes: X0 pins to (32767,-32768) in both builds, others zero.
    cycle("ext", 1'b1, mk(32767, -32768, 32767, -32768, 32767, -32768, 32767, -32768));
    cycle("ext", 1'b0, zero);
    cycle("ext", 1'b0, zero);
    check("ext.x0r", int'(bus.out0r), 32767);
    check("ext.x0i", int'(bus.out0i), -32768);
    check("ext.x2r", int'(bus.out2r), 0);

    // Four back-to-back distinct sets, then drain.
    for (int i = 0; i < 4; i++)
      cycle("stream", 1'b1, mk(1000 * (i + 1), -300 * i, 7 * i, 50, -2000, i, 123, -45 * i));
    for (int i = 0; i < 3; i++)
      cycle("stream", 1'b0, zero);

    // Asynchronous reset between edges with two sets in flight.
    cycle("pre_rst", 1'b1, rnd_in());
    cycle("pre_rst", 1'b1, rnd_in());
    #2;
    rst_n = 1'b0;
    model_reset();
    drive(1'b0, zero);
    #1;
    check_outputs("async_rst");
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++)
      cycle("post_rst", 1'b0, zero);

    // Random traffic with gaps.
    for (int i = 0; i < 300; i++)
      cycle("rand", ($urandom_range(0, 3) != 0), rnd_in());
    for (int i = 0; i < 3; i++)
      cycle("drain", 1'b0, zero);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
